// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, descriptor payload and immediate limits.
package riscv_pkg;

    localparam int unsigned KIND_W = 3;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned IMM_W  = 21;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [KIND_W-1:0] {
        KIND_R    = 3'd0,
        KIND_IALU = 3'd1,
        KIND_LW   = 3'd2,
        KIND_SW   = 3'd3,
        KIND_BEQ  = 3'd4,
        KIND_JAL  = 3'd5
    } kind_e;

    localparam int IMM_I_MIN  = -2048;
    localparam int IMM_I_MAX  = 2047;
    localparam int IMM_SH_MAX = 31;
    localparam int IMM_B_MIN  = -4096;
    localparam int IMM_B_MAX  = 4094;
    localparam int IMM_J_MIN  = -1048576;
    localparam int IMM_J_MAX  = 1048574;

    typedef struct packed {
        logic [KIND_W-1:0] kind;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic [IMM_W-1:0]  imm;
    } desc_t;

    // Inclusive range test; branch/jump offsets must also be halfword aligned.
    function automatic logic imm_ok(input int v, input int lo, input int hi, input logic even);
        return (v >= lo) && (v <= hi) && (!even || (v[0] == 1'b0));
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Descriptor-in / word-out valid-ready bus of the instruction encoder.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic [20:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_fmt_enc.sv
// Combinational RV32I field packing with immediate range and kind legality checks.
module instr_fmt_enc
    import riscv_pkg::*;
(
    input  desc_t       i_desc,
    output logic [31:0] o_word,
    output logic        o_imm_bad,
    output logic        o_kind_bad
);

    int          w_imm;
    logic [20:0] w_i;
    logic [6:0]  w_f7;
    logic        w_shift;

    always_comb begin
        w_i        = i_desc.imm;
        w_imm      = int'($signed(i_desc.imm));
        w_f7       = {1'b0, i_desc.funct7b5, 5'b00000};
        w_shift    = (i_desc.funct3 == 3'b001) || (i_desc.funct3 == 3'b101);
        o_word     = NOP;
        o_imm_bad  = 1'b0;
        o_kind_bad = 1'b0;
        case (i_desc.kind)
            KIND_R: o_word = {w_f7, i_desc.rs2, i_desc.rs1, i_desc.funct3, i_desc.rd, OP_R};
            KIND_IALU: begin
                if (w_shift) begin
                    o_imm_bad = !imm_ok(w_imm, 0, IMM_SH_MAX, 1'b0);
                    o_word    = {w_f7, w_i[4:0], i_desc.rs1, i_desc.funct3, i_desc.rd, OP_IALU};
                end else begin
                    o_imm_bad = !imm_ok(w_imm, IMM_I_MIN, IMM_I_MAX, 1'b0);
                    o_word    = {w_i[11:0], i_desc.rs1, i_desc.funct3, i_desc.rd, OP_IALU};
                end
            end
            KIND_LW: begin
                o_imm_bad = !imm_ok(w_imm, IMM_I_MIN, IMM_I_MAX, 1'b0);
                o_word    = {w_i[11:0], i_desc.rs1, 3'b010, i_desc.rd, OP_LOAD};
            end
            KIND_SW: begin
                o_imm_bad = !imm_ok(w_imm, IMM_I_MIN, IMM_I_MAX, 1'b0);
                o_word    = {w_i[11:5], i_desc.rs2, i_desc.rs1, 3'b010, w_i[4:0], OP_STORE};
            end
            KIND_BEQ: begin
                o_imm_bad = !imm_ok(w_imm, IMM_B_MIN, IMM_B_MAX, 1'b1);
                o_word    = {w_i[12], w_i[10:5], i_desc.rs2, i_desc.rs1, 3'b000,
                             w_i[4:1], w_i[11], OP_BRANCH};
            end
            KIND_JAL: begin
                o_imm_bad = !imm_ok(w_imm, IMM_J_MIN, IMM_J_MAX, 1'b1);
                o_word    = {w_i[20], w_i[10:1], w_i[11], w_i[19:12], i_desc.rd, OP_JAL};
            end
            default: o_kind_bad = 1'b1;
        endcase
        // Any rejected descriptor still produces a harmless word.
        if (o_imm_bad || o_kind_bad) o_word = NOP;
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder writing words to sequential instruction-memory addresses.
// INSTR_ENCODER_SKID_EN adds a 2-entry output buffer with a registered in_ready.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic           clk,
    input  logic           reset,
    instr_encoder_if.slave bus,
    input  logic           clr_err,
    output logic           err_imm,
    output logic           err_kind
);

    desc_t             w_desc;
    logic [31:0]       w_word;
    logic              w_imm_bad;
    logic              w_kind_bad;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err_imm;
    logic              r_err_kind;

    always_comb begin
        w_desc.kind     = bus.in_kind;
        w_desc.rd       = bus.in_rd;
        w_desc.rs1      = bus.in_rs1;
        w_desc.rs2      = bus.in_rs2;
        w_desc.funct3   = bus.in_funct3;
        w_desc.funct7b5 = bus.in_funct7b5;
        w_desc.imm      = bus.in_imm;
    end

    instr_fmt_enc u_fmt (
        .i_desc     (w_desc),
        .o_word     (w_word),
        .o_imm_bad  (w_imm_bad),
        .o_kind_bad (w_kind_bad)
    );

    assign w_in_fire  = bus.in_valid && bus.in_ready && !reset;
    assign w_out_fire = bus.out_valid && bus.out_ready;

    // Address of the word currently presented; advances per accepted word.
    always_ff @(posedge clk) begin
        if (reset)           r_addr <= ADDR_W'(BASE_ADDR);
        else if (w_out_fire) r_addr <= r_addr + ADDR_W'(1);
    end

    // Sticky flags: a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_imm  <= 1'b0;
            r_err_kind <= 1'b0;
        end else begin
            if (w_in_fire && w_imm_bad) r_err_imm <= 1'b1;
            else if (clr_err)           r_err_imm <= 1'b0;
            if (w_in_fire && w_kind_bad) r_err_kind <= 1'b1;
            else if (clr_err)            r_err_kind <= 1'b0;
        end
    end

    assign err_imm      = r_err_imm;
    assign err_kind     = r_err_kind;
    assign bus.out_addr = r_addr;

`ifdef INSTR_ENCODER_SKID_EN
    logic [31:0] r_mem [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        r_in_ready;
    logic        w_tail;
    logic [1:0]  w_count_nxt;

    assign w_tail      = r_head ^ r_count[0];
    assign w_count_nxt = r_count + 2'(w_in_fire) - 2'(w_out_fire);

    // Two-entry FIFO; ready is precomputed from the next occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_in_fire)  r_mem[w_tail] <= w_word;
            if (w_out_fire) r_head        <= ~r_head;
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_instr = r_mem[r_head];
`else
    logic        r_valid;
    logic [31:0] r_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
        end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_instr <= w_word;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = !reset && (!r_valid || bus.out_ready);
    assign bus.out_valid = r_valid;
    assign bus.out_instr = r_instr;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed RV32I cases plus randomized traffic vs a reference model.
module tb_instr_encoder;

    logic clk = 1'b0;
    logic reset;
    logic clr_err;
    logic err_imm, err_kind, err_imm2, err_kind2;
    int   n_checks = 0;
    int   n_errors = 0;

    instr_encoder_if #(.ADDR_W(8)) bus ();
    instr_encoder_if #(.ADDR_W(2)) bus2 ();

    assign bus2.in_valid    = bus.in_valid;
    assign bus2.in_kind     = bus.in_kind;
    assign bus2.in_rd       = bus.in_rd;
    assign bus2.in_rs1      = bus.in_rs1;
    assign bus2.in_rs2      = bus.in_rs2;
    assign bus2.in_funct3   = bus.in_funct3;
    assign bus2.in_funct7b5 = bus.in_funct7b5;
    assign bus2.in_imm      = bus.in_imm;
    assign bus2.out_ready   = bus.out_ready;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
        .clk(clk), .reset(reset), .bus(bus), .clr_err(clr_err), .err_imm(err_imm), .err_kind(err_kind)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .clr_err(clr_err), .err_imm(err_imm2), .err_kind(err_kind2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference encoder: assembles fields arithmetically from the ISA bit positions.
    function automatic void ref_enc(input int kind, input int rd, input int rs1, input int rs2,
                                    input int f3, input int f7b5, input int imm,
                                    output logic [31:0] w, output bit bi, output bit bk);
        int b;
        bi = 0; bk = 0; b = 0;
        case (kind)
            0: b = 'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7b5 << 30);
            1: if (f3 == 1 || f3 == 5) begin
                   bi = (imm < 0) || (imm > 31);
                   b  = 'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 31) << 20) | (f7b5 << 30);
               end else begin
                   bi = (imm < -2048) || (imm > 2047);
                   b  = 'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 4095) << 20);
               end
            2: begin
                   bi = (imm < -2048) || (imm > 2047);
                   b  = 'h03 | (rd << 7) | (2 << 12) | (rs1 << 15) | ((imm & 4095) << 20);
               end
            3: begin
                   bi = (imm < -2048) || (imm > 2047);
                   b  = 'h23 | ((imm & 31) << 7) | (2 << 12) | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 127) << 25);
               end
            4: begin
                   bi = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
                   b  = 'h63 | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (rs1 << 15) | (rs2 << 20)
                        | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
               end
            5: begin
                   bi = (imm < -1048576) || (imm > 1048574) || (imm % 2 != 0);
                   b  = 'h6F | (rd << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20)
                        | (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
               end
            default: bk = 1;
        endcase
        w = (bi || bk) ? 32'h0000_0013 : 32'(b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int kind, input int rd, input int rs1, input int rs2,
                         input int f3, input int f7b5, input int imm);
        bus.in_kind     = 3'(kind);
        bus.in_rd       = 5'(rd);
        bus.in_rs1      = 5'(rs1);
        bus.in_rs2      = 5'(rs2);
        bus.in_funct3   = 3'(f3);
        bus.in_funct7b5 = 1'(f7b5);
        bus.in_imm      = 21'(imm);
        bus.in_valid    = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.in_valid = 1'b0; clr_err = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; clr_err = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0); bus.in_valid = 1'b0;
        tick(); tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.out_instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr got=%h exp=00000000", bus.out_instr); end
        n_checks++; if (bus.out_addr !== 8'd0) begin n_errors++; $display("FAIL reset_addr got=%0d exp=0", bus.out_addr); end
        n_checks++; if (bus2.out_addr !== 2'd2) begin n_errors++; $display("FAIL reset_addr2 got=%0d exp=2", bus2.out_addr); end
        n_checks++; if (err_imm !== 1'b0 || err_kind !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b%b exp=00", err_imm, err_kind); end
        reset = 1'b0;
    endtask

    task automatic test_add();
        drive(0, 3, 1, 2, 0, 0, 0); bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL add_ready got=%b exp=1", bus.in_ready); end
        tick(); bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL add_valid got=%b exp=1", bus.out_valid); end
        n_checks++; if (bus.out_instr !== 32'h002081B3) begin n_errors++; $display("FAIL add_instr got=%h exp=002081b3", bus.out_instr); end
        n_checks++; if (bus.out_addr !== 8'd0) begin n_errors++; $display("FAIL add_addr got=%0d exp=0", bus.out_addr); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 8'd1) begin n_errors++; $display("FAIL add_after got=%b/%0d exp=0/1", bus.out_valid, bus.out_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset(); bus.out_ready = 1'b1;
        drive(2, 5, 2, 0, 0, 0, -4);
        tick();
        drive(3, 0, 2, 5, 0, 0, 8);
        n_checks++; if (bus.out_instr !== 32'hFFC12283 || bus.out_addr !== 8'd0 || bus.out_valid !== 1'b1)
            begin n_errors++; $display("FAIL b2b_lw got=%h@%0d exp=ffc12283@0", bus.out_instr, bus.out_addr); end
        tick(); bus.in_valid = 1'b0;
        n_checks++; if (bus.out_instr !== 32'h00512423 || bus.out_addr !== 8'd1 || bus.out_valid !== 1'b1)
            begin n_errors++; $display("FAIL b2b_sw got=%h@%0d exp=00512423@1", bus.out_instr, bus.out_addr); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_idle got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_branch_jump();
        drive(4, 0, 1, 2, 0, 0, -8);
        tick();
        drive(5, 1, 0, 0, 0, 0, 16);
        n_checks++; if (bus.out_instr !== 32'hFE208CE3 || bus.out_addr !== 8'd2)
            begin n_errors++; $display("FAIL beq got=%h@%0d exp=fe208ce3@2", bus.out_instr, bus.out_addr); end
        tick(); bus.in_valid = 1'b0;
        n_checks++; if (bus.out_instr !== 32'h010000EF || bus.out_addr !== 8'd3)
            begin n_errors++; $display("FAIL jal got=%h@%0d exp=010000ef@3", bus.out_instr, bus.out_addr); end
        tick();
    endtask

    task automatic test_errors();
        do_reset(); bus.out_ready = 1'b1;
        drive(4, 0, 1, 2, 0, 0, 5);
        tick(); bus.in_valid = 1'b0;
        n_checks++; if (bus.out_instr !== 32'h13 || bus.out_addr !== 8'd0) begin n_errors++; $display("FAIL odd_beq got=%h@%0d exp=00000013@0", bus.out_instr, bus.out_addr); end
        n_checks++; if (err_imm !== 1'b1 || err_kind !== 1'b0) begin n_errors++; $display("FAIL odd_beq_err got=%b%b exp=10", err_imm, err_kind); end
        tick(); tick();
        n_checks++; if (err_imm !== 1'b1 || bus.out_addr !== 8'd1) begin n_errors++; $display("FAIL err_hold got=%b/%0d exp=1/1", err_imm, bus.out_addr); end
        drive(7, 3, 1, 2, 0, 0, 0);
        tick(); bus.in_valid = 1'b0;
        n_checks++; if (bus.out_instr !== 32'h13 || bus.out_addr !== 8'd1) begin n_errors++; $display("FAIL kind7 got=%h@%0d exp=00000013@1", bus.out_instr, bus.out_addr); end
        n_checks++; if (err_kind !== 1'b1) begin n_errors++; $display("FAIL kind7_err got=%b exp=1", err_kind); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        n_checks++; if (err_imm !== 1'b0 || err_kind !== 1'b0) begin n_errors++; $display("FAIL clr_err got=%b%b exp=00", err_imm, err_kind); end
        drive(6, 0, 0, 0, 0, 0, 0); clr_err = 1'b1;
        tick(); bus.in_valid = 1'b0; clr_err = 1'b0;
        n_checks++; if (err_kind !== 1'b1) begin n_errors++; $display("FAIL set_wins got=%b exp=1", err_kind); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
    endtask

    task automatic test_imm_range();
        int kd[17] = '{1, 1, 1, 1, 1, 1, 1, 3, 3, 2, 4, 4, 4, 4, 5, 5, 5};
        int fs[17] = '{0, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int im[17] = '{2047, 2048, -2048, -2049, 31, 32, -1, -2048, 2048, 2047,
                       4094, 4096, -4096, -4098, -1048576, 1048574, 7};
        bit bd[17] = '{0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1};
        logic [31:0] w; bit bi, bk;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(kd[i], 7, 9, 11, fs[i], i % 2, im[i]);
            ref_enc(kd[i], 7, 9, 11, fs[i], i % 2, im[i], w, bi, bk);
            tick(); bus.in_valid = 1'b0;
            n_checks++; if (bus.out_instr !== w) begin n_errors++; $display("FAIL range_word[%0d] got=%h exp=%h", i, bus.out_instr, w); end
            n_checks++; if (err_imm !== bd[i]) begin n_errors++; $display("FAIL range_flag[%0d] got=%b exp=%b", i, err_imm, bd[i]); end
            clr_err = 1'b1; tick(); clr_err = 1'b0;
        end
    endtask

    task automatic test_stall();
        logic [31:0] q[$]; logic [31:0] wa, wb; bit bi, bk, fired; int ea = 0; int got = 0;
        do_reset(); bus.out_ready = 1'b0;
        ref_enc(0, 1, 2, 3, 0, 1, 0, wa, bi, bk);
        ref_enc(1, 4, 5, 0, 0, 0, -7, wb, bi, bk);
        drive(0, 1, 2, 3, 0, 1, 0);
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL stall_first_ready got=%b exp=1", bus.in_ready); end
        if (bus.in_ready) q.push_back(wa);
        tick();
        drive(1, 4, 5, 0, 0, 0, -7);
        for (int c = 0; c < 3; c++) begin
            #1;
            fired = bus.in_valid && bus.in_ready;
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== wa || bus.out_addr !== 8'd0)
                begin n_errors++; $display("FAIL stall_hold[%0d] got=%b %h@%0d exp=1 %h@0", c, bus.out_valid, bus.out_instr, bus.out_addr, wa); end
`ifndef INSTR_ENCODER_SKID_EN
            n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_ready[%0d] got=%b exp=0", c, bus.in_ready); end
`endif
            if (fired) q.push_back(wb);
            tick();
            if (fired) bus.in_valid = 1'b0;
        end
`ifdef INSTR_ENCODER_SKID_EN
        n_checks++; if (q.size() != 2) begin n_errors++; $display("FAIL stall_absorb got=%0d exp=2", q.size()); end
`endif
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            fired = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                n_checks++; if (q.size() == 0 || bus.out_instr !== q[0] || bus.out_addr !== 8'(ea))
                    begin n_errors++; $display("FAIL stall_drain got=%h@%0d exp_q=%0d addr=%0d", bus.out_instr, bus.out_addr, q.size(), ea); end
                if (q.size() != 0) void'(q.pop_front());
                ea++; got++;
            end
            if (fired) q.push_back(wb);
            tick();
            if (fired) bus.in_valid = 1'b0;
        end
        n_checks++; if (got != 2 || q.size() != 0 || bus.out_valid !== 1'b0)
            begin n_errors++; $display("FAIL stall_count got=%0d left=%0d exp=2 left=0", got, q.size()); end
    endtask

    task automatic test_random();
        logic [31:0] q[$]; logic [31:0] w; bit bi, bk, in_fire, out_fire, hold;
        int bl[8] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, 31};
        int kind, imm, f3, sel; bit ei = 0, ek = 0; int ea = 0;
        do_reset(); hold = 0; bi = 0; bk = 0;
        for (int c = 0; c < 400; c++) begin
            n_checks++; if (err_imm !== ei || err_kind !== ek) begin n_errors++; $display("FAIL rnd_err[%0d] got=%b%b exp=%b%b", c, err_imm, err_kind, ei, ek); end
            if (!hold) begin
                kind = int'($urandom_range(0, 7));
                f3   = int'($urandom_range(0, 7));
                sel  = int'($urandom_range(0, 3));
                case (sel)
                    0: imm = int'($urandom_range(0, 80)) - 40;
                    1: imm = int'($urandom_range(0, 2097151)) - 1048576;
                    2: imm = bl[$urandom_range(0, 7)];
                    default: imm = int'($urandom_range(0, 10000)) - 5000;
                endcase
                drive(kind, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      f3, int'($urandom_range(0, 1)), imm);
                ref_enc(kind, int'(bus.in_rd), int'(bus.in_rs1), int'(bus.in_rs2), f3, int'(bus.in_funct7b5), imm, w, bi, bk);
                bus.in_valid = ($urandom_range(0, 9) < 7);
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            clr_err = ($urandom_range(0, 19) == 0);
            #1;
            in_fire  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
`ifndef INSTR_ENCODER_SKID_EN
            n_checks++; if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin n_errors++; $display("FAIL rnd_ready[%0d] got=%b", c, bus.in_ready); end
`endif
            n_checks++; if (bus.out_valid !== (q.size() != 0)) begin n_errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, bus.out_valid, q.size() != 0); end
            if (out_fire && q.size() != 0) begin
                n_checks++; if (bus.out_instr !== q[0] || bus.out_addr !== 8'(ea))
                    begin n_errors++; $display("FAIL rnd_word[%0d] got=%h@%0d exp=%h@%0d", c, bus.out_instr, bus.out_addr, q[0], ea % 256); end
                void'(q.pop_front());
                ea = (ea + 1) % 256;
            end
            if (in_fire) q.push_back(w);
            if (in_fire && bi) ei = 1; else if (clr_err) ei = 0;
            if (in_fire && bk) ek = 1; else if (clr_err) ek = 0;
            hold = bus.in_valid && !in_fire;
            tick();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; clr_err = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (bus.out_valid && q.size() != 0) begin
                n_checks++; if (bus.out_instr !== q[0] || bus.out_addr !== 8'(ea))
                    begin n_errors++; $display("FAIL rnd_drain got=%h@%0d exp=%h@%0d", bus.out_instr, bus.out_addr, q[0], ea); end
                void'(q.pop_front()); ea = (ea + 1) % 256;
            end
            tick();
        end
        n_checks++; if (q.size() != 0 || bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL rnd_end left=%0d valid=%b exp=0/0", q.size(), bus.out_valid); end
    endtask

    task automatic test_wrap_reset();
        do_reset(); bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(1, i + 1, 0, 0, 0, 0, i); else bus.in_valid = 1'b0;
            if (i >= 1) begin
                n_checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 8'(i - 1) || bus2.out_addr !== 2'((i + 1) % 4))
                    begin n_errors++; $display("FAIL wrap[%0d] got=%0d/%0d exp=%0d/%0d", i, bus.out_addr, bus2.out_addr, i - 1, (i + 1) % 4); end
            end
            tick();
        end
        bus.out_ready = 1'b0;
        drive(0, 3, 1, 2, 0, 0, 0);
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 8'd5) begin n_errors++; $display("FAIL pre_reset got=%b@%0d exp=1@5", bus.out_valid, bus.out_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0; bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 8'd0 || bus2.out_addr !== 2'd2)
            begin n_errors++; $display("FAIL mid_reset got=%b %0d/%0d exp=0 0/2", bus.out_valid, bus.out_addr, bus2.out_addr); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_no_accept got=%b exp=0", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_branch_jump();
        test_errors();
        test_imm_range();
        test_stall();
        test_random();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder: turns instruction descriptors (kind, register fields, signed immediate) into 32-bit machine words.
- Writes the words, with sequential word addresses, into instruction memory. Used by the boot/program loader and by benches that build programs.
- Produces exactly the opcode and field encodings the main decoder consumes: R-type, I-type ALU, lw, sw, beq, jal.
- Valid/ready on input and output, one registered output stage, immediate range checking.

Parameters:
- ADDR_W, 8, width of the output word-address counter.
- BASE_ADDR, 0, word address loaded into the counter on reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  descriptor valid
- in_ready  out  1  encoder can accept a descriptor
- in_kind  in  3  0=R, 1=I-ALU, 2=LW, 3=SW, 4=BEQ, 5=JAL, 6/7=illegal
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  ALU funct3 (R / I-ALU only)
- in_funct7b5  in  1  sub/sra/srai selector
- in_imm  in  21  signed immediate (two's complement)
- out_valid  out  1  out_instr/out_addr valid
- out_ready  in  1  memory side accepts the word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address for out_instr
- clr_err  in  1  clears the sticky error flags
- err_imm  out  1  sticky: immediate out of range
- err_kind  out  1  sticky: illegal kind

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: out_valid=0, out_instr=0x00000000, out_addr=BASE_ADDR, err_imm=0, err_kind=0.
- Input handshake: a descriptor transfers on in_valid && in_ready.
  - Without skid: in_ready = !out_valid || out_ready (combinational).
  - Encoding is registered; latency 1 cycle from input transfer to out_valid=1.
- Output handshake:
  - out_instr and out_addr are held stable while out_valid && !out_ready.
  - A word transfers on out_valid && out_ready.
  - out_addr increments by 1 on each output transfer and wraps modulo 2^ADDR_W.
  - Simultaneous output transfer and input transfer gives back-to-back words, 1 word/cycle.
- Encoding:
  - R (kind 0): opcode 0110011, funct7 = {0, funct7b5, 00000}.
  - I-ALU (kind 1): opcode 0010011.
    - funct3 001/101: instr[31:25] = {0, funct7b5, 00000}, instr[24:20] = imm[4:0]; legal imm range 0..31.
    - Otherwise: instr[31:20] = imm[11:0].
  - LW (kind 2): opcode 0000011, funct3 forced to 010.
  - SW (kind 3): opcode 0100011, funct3 forced to 010, S-format immediate split.
  - BEQ (kind 4): opcode 1100011, funct3 forced to 000, B-format.
  - JAL (kind 5): opcode 1101111, J-format.
  - Fields a format does not use are ignored.
- Immediate ranges:
  - I/S: -2048..2047.
  - B: -4096..4094, even.
  - J: -1048576..1048574, even.
- Error handling:
  - Out-of-range immediate: emit NOP 0x00000013, set err_imm.
  - Illegal kind: emit NOP 0x00000013, set err_kind.
  - The NOP still consumes an address.
- Sticky flags: clear only on reset or clr_err. If a set and clr_err occur in the same cycle, set wins.
- Reset mid-transfer: a pending output word is dropped, out_addr returns to BASE_ADDR, the input is not accepted that cycle.

Optional Feature:
- Macro: INSTR_ENCODER_SKID_EN.
- Defined: a 2-entry output buffer is added.
  - in_ready is registered: in_ready = !(buffer full).
  - Full throughput is maintained; ordering is preserved.
  - Up to one extra word is accepted while out_ready is low.
- Undefined: single output register; in_ready is combinational as specified above.

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants: OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL.
  - The kind enum.
  - The NOP constant.
  - Immediate range limits.
- One sub-module, instr_fmt_enc: purely combinational field packing plus range check, outputs {word, imm_bad, kind_bad}.
- The top level owns the handshake, buffer, address counter and sticky flags.

Test Plan:
- add x3,x1,x2 (kind0, rd3, rs1=1, rs2=2, f3=0, f7b5=0) after reset -> out_instr=0x002081B3, out_addr=0.
- lw x5,-4(x2) then sw x5,8(x2), out_ready=1 -> 0xFFC12283 @0, 0x00512423 @1, back-to-back cycles.
- beq x1,x2,-8 then jal x1,16 -> 0xFE208CE3, then 0x010000EF.
- beq with imm=5 (odd) -> 0x00000013, err_imm=1 and held. kind=7 -> NOP, err_kind=1. clr_err pulse -> both 0.
- out_ready low for 3 cycles with in_valid high -> out_instr/out_addr stable, in_ready=0 (1 word absorbed with SKID_EN), no loss or duplication afterwards.
- ADDR_W=2: 5 words -> addresses 0,1,2,3,0. reset asserted while out_valid=1 -> next cycle out_valid=0, out_addr=BASE_ADDR.
